mem_exc_stage: RTL and testbench
================================

// Module: mem_exc_stage
// PURPOSE
//  Parametrised M->W data-access exception stage. It checks each M-stage load/store
//  for alignment and address-window legality (DM plus NUM_DEV MMIO devices) and merges
//  the result with the incoming ExcCodeM. The merged code and the faulting address are
//  registered into W. It keeps sticky first-fault capture and saturating AdEL/AdES counters.
// PARAMETERS
//  DM_HI       32'h0000_2FFF             top byte of data memory; DM spans 0..DM_HI
//  NUM_DEV     3                         number of MMIO device windows
//  DEV_BASE    {32'h7F20,32'h7F10,32'h7F00} packed 32b bases, device i at [32*i+:32]
//  DEV_LAST    {32'h7F23,32'h7F1B,32'h7F0B} packed 32b last byte address per device
//  DEV_WORDONLY 3'b011                   bit i=1: device i accepts only lw/sw
//  DEV_RO_OFF  32'h8                     word offset that is read-only in word-only devices
//  CNT_W       16                        width of fault counters
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  en           in   1   1: advance M->W register; 0: stall, hold all W outputs
//  flush        in   1   kill the instruction entering W (bubble)
//  clr          in   1   clear counters and sticky capture
//  MemtoRegM    in   1   M-stage instruction is a load
//  MemWriteM    in   1   M-stage instruction is a store
//  MemOpM       in   3   0 sw, 1 sh, 2 sb, 3 lw, 4 lh, 5 lb; 6,7 illegal
//  AddressM     in   32  effective byte address
//  ExcCodeM     in   5   exception code from earlier stages, 0 = none
//  ExcCodeW     out  5   registered merged code: 0 none, 4 AdEL, 5 AdES, else passthrough
//  BadVAddrW    out  32  registered AddressM when ExcCodeW is 4/5 and comes from this stage, else 0
//  first_valid  out  1   sticky: a fault has been captured since the last reset/clr
//  first_addr   out  32  address of the first captured fault
//  first_code   out  5   code (4/5) of the first captured fault
//  adel_cnt     out  CNT_W saturating count of AdEL raised here
//  ades_cnt     out  CNT_W saturating count of AdES raised here
// BEHAVIOUR
//  Reset: all outputs 0. Asynchronous assert, synchronous release on clk.
//  Combinational check on M inputs:
//   - size: word for op 0/3, half for 1/4, byte for 2/5; aligned = (word: A[1:0]==0, half: A[0]==0).
//   - in_dm: A<=DM_HI. in_dev[i]: DEV_BASE[i]<=A<=DEV_LAST[i].
//   - legal: aligned AND (in_dm OR any in_dev[i]). Word-only devices reject half/byte access.
//     A store to DEV_BASE[i]+DEV_RO_OFF in a word-only device is illegal.
//   - fault_l = MemtoRegM & ~legal -> 4; fault_s = MemWriteM & ~legal -> 5.
//   - Op 6/7 with MemtoRegM -> 4; with MemWriteM -> 5.
//   - Both MemtoRegM and MemWriteM set: the store check wins (5).
//   - Priority: ExcCodeM!=0 passes through unchanged. Local fault is ignored and not counted.
//  Register update, at posedge when en=1:
//   - flush=1: ExcCodeW<=0, BadVAddrW<=0. No count, no capture. Flush wins over fault.
//   - else: ExcCodeW<=merged code; BadVAddrW<=AddressM if local fault else 0.
//  en=0: W registers, counters and capture hold. A stalled instruction is never counted twice.
//  Counters: increment by 1 on a non-flushed, enabled local fault. They saturate at all-ones.
//  Capture: on the first counted fault while first_valid=0, latch address and code and set
//   first_valid. Later faults do not overwrite it.
//  clr=1 (synchronous, independent of en): counters<=0, first_valid<=0, first_addr/code<=0.
//   clr wins over a same-cycle fault; that fault is not counted.
//  Latency: 1 cycle M->W. Mid-operation reset clears everything, including a pending stall.
// TESTING
//  lw A=0x2FFC, ExcCodeM=0, en=1 -> next cycle ExcCodeW=0, BadVAddrW=0, adel_cnt=0.
//  lh A=0x7F04 (word-only dev0) -> ExcCodeW=4, BadVAddrW=0x7F04, first_valid=1, first_code=4.
//  sw A=0x7F08, then sw A=0x7F18 -> both ExcCodeW=5; ades_cnt=2; first_addr stays 0x7F08.
//  sb A=0x3000 with ExcCodeM=10 -> ExcCodeW=10, BadVAddrW=0, ades_cnt unchanged.
//  sw A=0x7F21 held 3 cycles with en=0, then en=1 -> ades_cnt +1 exactly. Same with flush=1 -> ExcCodeW=0, no count.
//  Force adel_cnt=0xFFFF, then lw A=0x1 -> stays 0xFFFF. Then clr=1 with a faulting lw -> cnt=0, first_valid=0.

Source files
------------

// File: rtl/mem_exc_stage_if.sv
// mem_exc_stage_if
//   Bundles the M-stage data-access request and the registered W-stage
//   exception result of the data-access exception stage.
//   master: the pipeline side, drives the M-stage request and observes W.
//   slave : the exception stage, observes the M-stage request and drives W.
// Signals
//   MemtoRegM  M-stage instruction is a load
//   MemWriteM  M-stage instruction is a store
//   MemOpM     access kind: 0 sw, 1 sh, 2 sb, 3 lw, 4 lh, 5 lb, 6/7 illegal
//   AddressM   effective byte address
//   ExcCodeM   exception code from earlier stages, 0 = none
//   ExcCodeW   registered merged exception code
//   BadVAddrW  registered faulting address for faults raised by this stage
interface mem_exc_stage_if;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [2:0]  MemOpM;
  logic [31:0] AddressM;
  logic [4:0]  ExcCodeM;
  logic [4:0]  ExcCodeW;
  logic [31:0] BadVAddrW;

  modport master (
    output MemtoRegM, MemWriteM, MemOpM, AddressM, ExcCodeM,
    input  ExcCodeW, BadVAddrW
  );

  modport slave (
    input  MemtoRegM, MemWriteM, MemOpM, AddressM, ExcCodeM,
    output ExcCodeW, BadVAddrW
  );
endinterface

// File: rtl/mem_exc_stage.sv
// mem_exc_stage
//   M->W data-access exception stage. Each M-stage load/store is checked for
//   alignment and for landing in a legal address window (data memory or one of
//   NUM_DEV MMIO devices). A local fault (AdEL=4 / AdES=5) is merged with the
//   code arriving from earlier stages and registered into W together with the
//   faulting address. Saturating AdEL/AdES counters and a sticky first-fault
//   capture are kept alongside.
// Ports
//   clk, reset   clock (rising edge) and asynchronous active-high reset
//   en           1 advances the M->W register, 0 stalls everything except clr
//   flush        turns the instruction entering W into a bubble
//   clr          synchronous clear of counters and first-fault capture
//   bus          mem_exc_stage_if.slave: M-stage request in, W result out
//   first_valid  a fault has been captured since reset/clr
//   first_addr   address of the captured fault
//   first_code   code (4/5) of the captured fault
//   adel_cnt     saturating count of AdEL raised here
//   ades_cnt     saturating count of AdES raised here
module mem_exc_stage #(
  parameter logic [31:0]           DM_HI        = 32'h0000_2FFF,
  parameter int                    NUM_DEV      = 3,
  parameter logic [32*NUM_DEV-1:0] DEV_BASE     = {32'h7F20, 32'h7F10, 32'h7F00},
  parameter logic [32*NUM_DEV-1:0] DEV_LAST     = {32'h7F23, 32'h7F1B, 32'h7F0B},
  parameter logic [NUM_DEV-1:0]    DEV_WORDONLY = 3'b011,
  parameter logic [31:0]           DEV_RO_OFF   = 32'h8,
  parameter int                    CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              clr,
  mem_exc_stage_if.slave    bus,
  output logic              first_valid,
  output logic [31:0]       first_addr,
  output logic [4:0]        first_code,
  output logic [CNT_W-1:0]  adel_cnt,
  output logic [CNT_W-1:0]  ades_cnt
);

  localparam logic [4:0]       CODE_ADEL = 5'd4;
  localparam logic [4:0]       CODE_ADES = 5'd5;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic               is_word, is_half, op_bad, aligned, in_dm;
  logic [NUM_DEV-1:0] dev_ld_ok, dev_st_ok;
  logic               legal_ld, legal_st, fault_ld, fault_st;
  logic [4:0]         local_code, merged_code;
  logic               local_fault, count_evt;

  logic [4:0]       exc_w_q, exc_w_d;
  logic [31:0]      badv_w_q, badv_w_d;
  logic             first_valid_q, first_valid_d;
  logic [31:0]      first_addr_q, first_addr_d;
  logic [4:0]       first_code_q, first_code_d;
  logic [CNT_W-1:0] adel_cnt_q, adel_cnt_d;
  logic [CNT_W-1:0] ades_cnt_q, ades_cnt_d;

  // Legality check of the M-stage access. Loads and stores are judged
  // separately because the read-only word of word-only devices only
  // rejects stores; when both flags are set the store verdict wins.
  always_comb begin
    is_word   = (bus.MemOpM == 3'd0) || (bus.MemOpM == 3'd3);
    is_half   = (bus.MemOpM == 3'd1) || (bus.MemOpM == 3'd4);
    op_bad    = (bus.MemOpM > 3'd5);
    aligned   = is_word ? (bus.AddressM[1:0] == 2'b00) :
                is_half ? ~bus.AddressM[0] : 1'b1;
    in_dm     = (bus.AddressM <= DM_HI);
    dev_ld_ok = '0;
    dev_st_ok = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_ld_ok[i] = (bus.AddressM >= DEV_BASE[32*i +: 32]) &&
                     (bus.AddressM <= DEV_LAST[32*i +: 32]) &&
                     (!DEV_WORDONLY[i] || is_word);
      dev_st_ok[i] = dev_ld_ok[i] &&
                     !(DEV_WORDONLY[i] &&
                       (bus.AddressM == DEV_BASE[32*i +: 32] + DEV_RO_OFF));
    end
    legal_ld = !op_bad && aligned && (in_dm || (|dev_ld_ok));
    legal_st = !op_bad && aligned && (in_dm || (|dev_st_ok));
    fault_ld = bus.MemtoRegM && !legal_ld;
    fault_st = bus.MemWriteM && !legal_st;
    local_code = fault_st ? CODE_ADES : (fault_ld ? CODE_ADEL : 5'd0);
  end

  // An earlier-stage exception has priority and masks the local fault, so
  // such a fault is neither reported with an address nor counted.
  always_comb begin
    local_fault = (bus.ExcCodeM == 5'd0) && (local_code != 5'd0);
    merged_code = (bus.ExcCodeM != 5'd0) ? bus.ExcCodeM : local_code;
    count_evt   = en && !flush && local_fault;
  end

  // Next-state logic. The W register only moves when enabled, so a stalled
  // instruction is counted exactly once, on the cycle it advances. clr acts
  // regardless of en and overrides a same-cycle count.
  always_comb begin
    exc_w_d       = exc_w_q;
    badv_w_d      = badv_w_q;
    first_valid_d = first_valid_q;
    first_addr_d  = first_addr_q;
    first_code_d  = first_code_q;
    adel_cnt_d    = adel_cnt_q;
    ades_cnt_d    = ades_cnt_q;

    if (en) begin
      if (flush) begin
        exc_w_d  = 5'd0;
        badv_w_d = 32'd0;
      end else begin
        exc_w_d  = merged_code;
        badv_w_d = local_fault ? bus.AddressM : 32'd0;
      end
    end

    if (clr) begin
      first_valid_d = 1'b0;
      first_addr_d  = 32'd0;
      first_code_d  = 5'd0;
      adel_cnt_d    = '0;
      ades_cnt_d    = '0;
    end else if (count_evt) begin
      if (local_code == CODE_ADEL) begin
        if (adel_cnt_q != '1) adel_cnt_d = adel_cnt_q + CNT_ONE;
      end else begin
        if (ades_cnt_q != '1) ades_cnt_d = ades_cnt_q + CNT_ONE;
      end
      if (!first_valid_q) begin
        first_valid_d = 1'b1;
        first_addr_d  = bus.AddressM;
        first_code_d  = local_code;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_w_q       <= 5'd0;
      badv_w_q      <= 32'd0;
      first_valid_q <= 1'b0;
      first_addr_q  <= 32'd0;
      first_code_q  <= 5'd0;
      adel_cnt_q    <= '0;
      ades_cnt_q    <= '0;
    end else begin
      exc_w_q       <= exc_w_d;
      badv_w_q      <= badv_w_d;
      first_valid_q <= first_valid_d;
      first_addr_q  <= first_addr_d;
      first_code_q  <= first_code_d;
      adel_cnt_q    <= adel_cnt_d;
      ades_cnt_q    <= ades_cnt_d;
    end
  end

  assign bus.ExcCodeW  = exc_w_q;
  assign bus.BadVAddrW = badv_w_q;
  assign first_valid   = first_valid_q;
  assign first_addr    = first_addr_q;
  assign first_code    = first_code_q;
  assign adel_cnt      = adel_cnt_q;
  assign ades_cnt      = ades_cnt_q;

endmodule

// File: tb/tb_mem_exc_stage.sv
// tb_mem_exc_stage
//   Scoreboard bench for mem_exc_stage. Two instances see identical stimulus:
//   the default one (16-bit counters) and one with 3-bit counters so that
//   counter saturation is reachable in a few cycles. Each driven cycle pushes
//   the expected post-edge state into a queue; it is popped and compared
//   just after the clock edge.
module tb_mem_exc_stage;

  logic clk;
  logic reset;
  logic en, flush, clr;

  mem_exc_stage_if bus ();
  mem_exc_stage_if bus_s ();

  logic        first_valid, first_valid_s;
  logic [31:0] first_addr, first_addr_s;
  logic [4:0]  first_code, first_code_s;
  logic [15:0] adel_cnt, ades_cnt;
  logic [2:0]  adel_cnt_s, ades_cnt_s;

  mem_exc_stage dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .clr(clr), .bus(bus),
    .first_valid(first_valid), .first_addr(first_addr), .first_code(first_code),
    .adel_cnt(adel_cnt), .ades_cnt(ades_cnt)
  );

  mem_exc_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .clr(clr), .bus(bus_s),
    .first_valid(first_valid_s), .first_addr(first_addr_s), .first_code(first_code_s),
    .adel_cnt(adel_cnt_s), .ades_cnt(ades_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  exc_w;
    logic [31:0] badv;
    logic        fv;
    logic [31:0] fa;
    logic [4:0]  fc;
    logic [15:0] adel;
    logic [15:0] ades;
    logic [2:0]  adel_s;
    logic [2:0]  ades_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  int checks = 0;
  int errors = 0;

  // Reference model of the address map, written directly from the memory map.
  function automatic logic [4:0] ref_code(logic ld, logic st, logic [2:0] op, logic [31:0] a);
    logic word, half, bad, al, dm, d0, d1, d2, ok_ld, ok_st;
    word  = (op == 3'd0) || (op == 3'd3);
    half  = (op == 3'd1) || (op == 3'd4);
    bad   = (op >= 3'd6);
    al    = word ? (a[1:0] == 2'b00) : (half ? (a[0] == 1'b0) : 1'b1);
    dm    = (a <= 32'h2FFF);
    d0    = (a >= 32'h7F00) && (a <= 32'h7F0B) && word;
    d1    = (a >= 32'h7F10) && (a <= 32'h7F1B) && word;
    d2    = (a >= 32'h7F20) && (a <= 32'h7F23);
    ok_ld = !bad && al && (dm || d0 || d1 || d2);
    ok_st = ok_ld && (a != 32'h7F08) && (a != 32'h7F18);
    if (st && !ok_st) return 5'd5;
    if (ld && !ok_ld) return 5'd4;
    return 5'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic compareAll(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty got 0x1 expected 0x0", tag);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, ".ExcCodeW"},   32'(bus.ExcCodeW),   32'(e.exc_w));
    checkOutput({tag, ".BadVAddrW"},  bus.BadVAddrW,       e.badv);
    checkOutput({tag, ".first_valid"},32'(first_valid),    32'(e.fv));
    checkOutput({tag, ".first_addr"}, first_addr,          e.fa);
    checkOutput({tag, ".first_code"}, 32'(first_code),     32'(e.fc));
    checkOutput({tag, ".adel_cnt"},   32'(adel_cnt),       32'(e.adel));
    checkOutput({tag, ".ades_cnt"},   32'(ades_cnt),       32'(e.ades));
    checkOutput({tag, ".adel_sat"},   32'(adel_cnt_s),     32'(e.adel_s));
    checkOutput({tag, ".ades_sat"},   32'(ades_cnt_s),     32'(e.ades_s));
  endtask

  // Drive one cycle of stimulus on the falling edge, advance the model,
  // push its expectation, then compare just after the rising edge.
  task automatic applyStimulus(input string tag, input logic ld, input logic st,
                               input logic [2:0] op, input logic [31:0] a,
                               input logic [4:0] exc, input logic e_n,
                               input logic fl, input logic cl);
    logic [4:0] lc;
    logic       fault;
    @(negedge clk);
    bus.MemtoRegM = ld;  bus_s.MemtoRegM = ld;
    bus.MemWriteM = st;  bus_s.MemWriteM = st;
    bus.MemOpM    = op;  bus_s.MemOpM    = op;
    bus.AddressM  = a;   bus_s.AddressM  = a;
    bus.ExcCodeM  = exc; bus_s.ExcCodeM  = exc;
    en = e_n; flush = fl; clr = cl;

    lc    = ref_code(ld, st, op, a);
    fault = (exc == 5'd0) && (lc != 5'd0);
    if (e_n) begin
      m.exc_w = fl ? 5'd0 : ((exc != 5'd0) ? exc : lc);
      m.badv  = (!fl && fault) ? a : 32'd0;
    end
    if (cl) begin
      m.fv = 1'b0; m.fa = 32'd0; m.fc = 5'd0;
      m.adel = 16'd0; m.ades = 16'd0; m.adel_s = 3'd0; m.ades_s = 3'd0;
    end else if (e_n && !fl && fault) begin
      if (lc == 5'd4) begin
        if (m.adel != 16'hFFFF) m.adel = m.adel + 16'd1;
        if (m.adel_s != 3'd7)   m.adel_s = m.adel_s + 3'd1;
      end else begin
        if (m.ades != 16'hFFFF) m.ades = m.ades + 16'd1;
        if (m.ades_s != 3'd7)   m.ades_s = m.ades_s + 3'd1;
      end
      if (!m.fv) begin
        m.fv = 1'b1; m.fa = a; m.fc = lc;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m = '0;
    reset = 1'b1;
    en = 1'b0; flush = 1'b0; clr = 1'b0;
    bus.MemtoRegM = 1'b0; bus.MemWriteM = 1'b0; bus.MemOpM = 3'd0;
    bus.AddressM = 32'd0; bus.ExcCodeM = 5'd0;
    bus_s.MemtoRegM = 1'b0; bus_s.MemWriteM = 1'b0; bus_s.MemOpM = 3'd0;
    bus_s.AddressM = 32'd0; bus_s.ExcCodeM = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(m);
    compareAll("reset");
    @(negedge clk);
    reset = 1'b0;

    // Legal word load at the top of data memory.
    applyStimulus("lw_dm_top", 1, 0, 3'd3, 32'h2FFC, 5'd0, 1, 0, 0);
    // Half load into a word-only device.
    applyStimulus("lh_dev0",   1, 0, 3'd4, 32'h7F04, 5'd0, 1, 0, 0);
    // Store to the read-only word of dev0 and dev1.
    applyStimulus("sw_ro0",    0, 1, 3'd0, 32'h7F08, 5'd0, 1, 0, 0);
    applyStimulus("sw_ro1",    0, 1, 3'd0, 32'h7F18, 5'd0, 1, 0, 0);
    // Earlier-stage exception masks a local fault.
    applyStimulus("sb_pass",   0, 1, 3'd2, 32'h3000, 5'd10, 1, 0, 0);
    // Various legal/illegal patterns.
    applyStimulus("lw_ro_ok",  1, 0, 3'd3, 32'h7F08, 5'd0, 1, 0, 0);
    applyStimulus("sb_dev2",   0, 1, 3'd2, 32'h7F23, 5'd0, 1, 0, 0);
    applyStimulus("lb_beyond", 1, 0, 3'd5, 32'h3000, 5'd0, 1, 0, 0);
    applyStimulus("sh_misal",  0, 1, 3'd1, 32'h0101, 5'd0, 1, 0, 0);
    applyStimulus("lw_gap",    1, 0, 3'd3, 32'h7F0C, 5'd0, 1, 0, 0);
    applyStimulus("op6_ld",    1, 0, 3'd6, 32'h0000, 5'd0, 1, 0, 0);
    applyStimulus("op7_st",    0, 1, 3'd7, 32'h0010, 5'd0, 1, 0, 0);
    applyStimulus("both_ro",   1, 1, 3'd3, 32'h7F18, 5'd0, 1, 0, 0);
    applyStimulus("no_mem",    0, 0, 3'd3, 32'h0001, 5'd0, 1, 0, 0);
    applyStimulus("pass_adel", 1, 0, 3'd3, 32'h0002, 5'd4, 1, 0, 0);

    // Stalled faulting store, then released.
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_sw",  0, 1, 3'd0, 32'h7F21, 5'd0, 0, 0, 0);
    applyStimulus("release_sw",  0, 1, 3'd0, 32'h7F21, 5'd0, 1, 0, 0);
    // Same with flush on release.
    for (int i = 0; i < 3; i++)
      applyStimulus("stall_fl",  0, 1, 3'd0, 32'h7F21, 5'd0, 0, 0, 0);
    applyStimulus("release_fl",  0, 1, 3'd0, 32'h7F21, 5'd0, 1, 1, 0);

    // Drive the small counters into saturation with misaligned loads.
    for (int i = 0; i < 9; i++)
      applyStimulus("sat_lw",    1, 0, 3'd3, 32'h0001, 5'd0, 1, 0, 0);
    // clr beats a same-cycle fault, also while stalled.
    applyStimulus("clr_fault",   1, 0, 3'd3, 32'h0001, 5'd0, 1, 0, 1);
    applyStimulus("fault_again", 0, 1, 3'd1, 32'h7F11, 5'd0, 1, 0, 0);
    applyStimulus("clr_stall",   1, 0, 3'd3, 32'h0001, 5'd0, 0, 0, 1);

    // Randomised traffic around the windows.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] base;
      case ($urandom_range(0, 3))
        0: base = 32'h2FF8;
        1: base = 32'h7F00;
        2: base = 32'h7F10;
        default: base = 32'h7F1C;
      endcase
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), base + 32'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) == 0) ? 5'd12 : 5'd0,
                    ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a stall with a faulting access pending.
    @(negedge clk);
    en = 1'b0;
    bus.MemtoRegM = 1'b1; bus_s.MemtoRegM = 1'b1;
    bus.MemWriteM = 1'b0; bus_s.MemWriteM = 1'b0;
    bus.AddressM = 32'h0003; bus_s.AddressM = 32'h0003;
    #2 reset = 1'b1;
    #1;
    m = '0;
    exp_q.push_back(m);
    compareAll("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("post_reset", 1, 0, 3'd3, 32'h0003, 5'd0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
